row_weight_sequencer: RTL

//   Sequences the weight-row ROM for the two-neuron array. On start it walks ROM rows 0..S-1 and

---
 rtl/row_seq_pkg.sv | 14 +
 rtl/row_addr_counter.sv | 33 +++
 rtl/row_weight_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/row_seq_pkg.sv
// Shared constants for the weight-row sequencer: FSM state encoding
// and default lane geometry (LANE_W = N + CL bits per lane).
package row_seq_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int SEQ_N  = 16;
  localparam int SEQ_CL = 8;
  localparam int LANE_W = SEQ_N + SEQ_CL;

endpackage

// File: rtl/row_addr_counter.sv
// Saturating ROM row counter that rests on park row S.
// clr: park at S; inc: S->0, else +1 up to S-1. addr, is_last (addr==S-1).
module row_addr_counter #(
  parameter int S  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          is_last
);

  localparam logic [AW-1:0] PARK = AW'(S);
  localparam logic [AW-1:0] LAST = AW'(S - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= PARK;
    end else if (clr) begin
      addr <= PARK;
    end else if (inc) begin
      if (addr == PARK)
        addr <= '0;
      else if (addr != LAST)
        addr <= addr + 1'b1;
    end
  end

  assign is_last = (addr == LAST);

endmodule

// File: rtl/row_weight_sequencer.sv
// Walks weight ROM rows 0..S-1, issuing each over valid/ready, then pulses done.
// Ports: start/abort, rom_addr/rom_w, row_* handshake bundle, busy, done.
// Optional SEQ_DUAL_ISSUE_EN: every row is issued twice (row_pass 0 then 1).
module row_weight_sequencer
  import row_seq_pkg::*;
#(
  parameter int M     = 8,
  parameter int S     = 8,
  parameter int N     = SEQ_N,
  parameter int CL    = SEQ_CL,
  // address must be able to reach park row S
  parameter int ADDRW = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDRW:0]        rom_addr,
  input  logic [M*(N+CL)-1:0]   rom_w,
  output logic [M*(N+CL)-1:0]   row_data,
  output logic [ADDRW:0]        row_idx,
  output logic                  row_pass,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic                  row_last,
  output logic                  busy,
  output logic                  done
);

`ifdef SEQ_DUAL_ISSUE_EN
  localparam logic DUAL = 1'b1;
`else
  localparam logic DUAL = 1'b0;
`endif

  logic [1:0]     state;
  logic           pass;
  logic           last_q;
  logic [ADDRW:0] addr;
  logic           is_last;
  logic           hs;
  logic           row_fin;
  logic           to_done;
  logic           cnt_clr;
  logic           cnt_inc;

  // a row is finished only by the handshake of its final pass
  assign hs      = (state == ISSUE) & row_ready & ~abort;
  assign row_fin = hs & (pass | ~DUAL);
  assign to_done = hs & last_q;
  assign cnt_clr = abort | to_done;
  assign cnt_inc = ((state == IDLE) & start) | row_fin;

  row_addr_counter #(
    .S  (S),
    .AW (ADDRW + 1)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .addr    (addr),
    .is_last (is_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pass     <= 1'b0;
      last_q   <= 1'b0;
      row_data <= '0;
      row_idx  <= '0;
      row_pass <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          pass <= 1'b0;
          if (!abort && start)
            state <= FETCH;
        end
        FETCH: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            row_data <= rom_w;
            row_idx  <= addr;
            row_pass <= pass;
            last_q   <= is_last & (pass | ~DUAL);
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort) begin
            state <= IDLE;
          end else if (row_ready) begin
            if (last_q) begin
              state <= DONE;
            end else begin
              state <= FETCH;
              pass  <= DUAL & ~pass;
            end
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  assign rom_addr  = addr;
  assign row_valid = (state == ISSUE);
  assign row_last  = row_valid & last_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
